// File: rtl/mem_fill_if.sv
// Fill-request / line-return bus between the cache miss path and the memory responder,
// plus the side port used to preload the backing store.
`timescale 1ns/1ps
interface mem_fill_if #(
    parameter int WORD_WIDTH = 64
) ();
    logic                  fill_req;
    logic [31:0]           fill_address;
    logic                  fill_busy;
    logic                  fill_valid;
    logic                  fill_last;
    logic [WORD_WIDTH-1:0] fill_data;
    logic                  load_en;
    logic [31:0]           load_address;
    logic [WORD_WIDTH-1:0] load_data;

    modport master (
        output fill_req, fill_address, load_en, load_address, load_data,
        input  fill_busy, fill_valid, fill_last, fill_data
    );

    modport slave (
        input  fill_req, fill_address, load_en, load_address, load_data,
        output fill_busy, fill_valid, fill_last, fill_data
    );
endinterface

// File: rtl/mem_fill_responder.sv
// Main-memory responder: returns a 4-word block in ascending order LATENCY cycles after
// accepting a fill request; backing store is written through a side load port.
`timescale 1ns/1ps
module mem_fill_responder #(
    parameter int WORD_WIDTH  = 64,
    parameter int BLOCK_WORDS = 4,
    parameter int DEPTH       = 1024,
    parameter int LATENCY     = 2
) (
    input  logic      clock,
    input  logic      reset,
    mem_fill_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFS_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    state_t                state, state_n;
    logic [IDX_W-OFS_W-1:0] blk, blk_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [OFS_W-1:0]      k, k_n;
    logic                  busy, busy_n;
    logic                  valid, valid_n;
    logic                  last, last_n;
    logic [WORD_WIDTH-1:0] data, data_n;

    // High address bits wrap the store and the block offset is discarded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.fill_address[31:IDX_W], bus.fill_address[OFS_W-1:0],
                                bus.load_address[31:IDX_W]};

    // Loads land as NBAs, so a same-edge burst read still sees the old word.
    always_ff @(posedge clock) begin
        if (bus.load_en) mem[bus.load_address[IDX_W-1:0]] <= bus.load_data;
    end

    always_comb begin
        state_n = state;
        blk_n   = blk;
        cnt_n   = cnt;
        k_n     = k;
        busy_n  = busy;
        valid_n = valid;
        last_n  = last;
        data_n  = data;
        case (state)
            IDLE: begin
                if (bus.fill_req) begin
                    blk_n   = bus.fill_address[IDX_W-1:OFS_W];
                    cnt_n   = CNT_W'(LATENCY - 1);
                    busy_n  = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    data_n  = mem[{blk, {OFS_W{1'b0}}}];
                    valid_n = 1'b1;
                    last_n  = 1'b0;
                    k_n     = OFS_W'(1);
                    state_n = BURST;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            BURST: begin
                // One extra edge after the last word to drop valid/busy.
                if (last) begin
                    valid_n = 1'b0;
                    last_n  = 1'b0;
                    busy_n  = 1'b0;
                    k_n     = '0;
                    state_n = IDLE;
                end else begin
                    data_n = mem[{blk, k}];
                    last_n = (k == OFS_W'(BLOCK_WORDS - 1));
                    k_n    = k + OFS_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            blk   <= '0;
            cnt   <= '0;
            k     <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
            last  <= 1'b0;
            data  <= '0;
        end else begin
            state <= state_n;
            blk   <= blk_n;
            cnt   <= cnt_n;
            k     <= k_n;
            busy  <= busy_n;
            valid <= valid_n;
            last  <= last_n;
            data  <= data_n;
        end
    end

    assign bus.fill_busy  = busy;
    assign bus.fill_valid = valid;
    assign bus.fill_last  = last;
    assign bus.fill_data  = data;
endmodule

// File: tb/tb_mem_fill_responder.sv
// Directed bench: cycle-by-cycle vector table on a LATENCY=2 responder, plus reset and
// latency sequences on LATENCY=1 and LATENCY=5 instances.
`timescale 1ns/1ps
module tb_mem_fill_responder;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_fill_if #(.WORD_WIDTH(64)) b2 ();
    mem_fill_if #(.WORD_WIDTH(64)) b1 ();
    mem_fill_if #(.WORD_WIDTH(64)) b5 ();

    mem_fill_responder #(.WORD_WIDTH(64), .BLOCK_WORDS(4), .DEPTH(1024), .LATENCY(2))
        dut (.clock(clock), .reset(reset), .bus(b2));
    mem_fill_responder #(.WORD_WIDTH(64), .BLOCK_WORDS(4), .DEPTH(1024), .LATENCY(1))
        dut1 (.clock(clock), .reset(reset), .bus(b1));
    mem_fill_responder #(.WORD_WIDTH(64), .BLOCK_WORDS(4), .DEPTH(1024), .LATENCY(5))
        dut5 (.clock(clock), .reset(reset), .bus(b5));

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        ld;
        logic [31:0] la;
        logic [63:0] ldat;
        logic        busy;
        logic        vld;
        logic        last;
        logic [63:0] data;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_all(input logic [31:0] a, input logic [63:0] d);
        b2.load_en = 1'b1; b2.load_address = a; b2.load_data = d;
        b1.load_en = 1'b1; b1.load_address = a; b1.load_data = d;
        b5.load_en = 1'b1; b5.load_address = a; b5.load_data = d;
        tick();
        b2.load_en = 1'b0; b1.load_en = 1'b0; b5.load_en = 1'b0;
    endtask

    function automatic void row(input logic req, input logic [31:0] addr, input logic ld,
                                input logic [31:0] la, input logic [63:0] ldat,
                                input logic busy, input logic vld, input logic last,
                                input logic [63:0] data);
        vec_t v;
        v.req = req; v.addr = addr; v.ld = ld; v.la = la; v.ldat = ldat;
        v.busy = busy; v.vld = vld; v.last = last; v.data = data;
        vecs.push_back(v);
    endfunction

    initial begin
        int n;
        logic v, bz, l;
        logic [63:0] dd;

        {b2.fill_req, b2.load_en, b1.fill_req, b1.load_en, b5.fill_req, b5.load_en} = '0;
        b2.fill_address = '0; b1.fill_address = '0; b5.fill_address = '0;
        b2.load_address = '0; b1.load_address = '0; b5.load_address = '0;
        b2.load_data = '0;    b1.load_data = '0;    b5.load_data = '0;

        #12;
        chk("rst busy", b2.fill_busy, 0);
        chk("rst valid", b2.fill_valid, 0);
        chk("rst last", b2.fill_last, 0);
        chk("rst data", b2.fill_data, 0);
        #5 reset = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            load_all(32'h08 + i, 64'hA0 + i);
            load_all(32'h10 + i, 64'hB0 + i);
            load_all(32'h30 + i, 64'hC0 + i);
            load_all(32'h00 + i, 64'hD0 + i);
            load_all(32'h20 + i, 64'hE0 + i);
            load_all(32'h40 + i, 64'hF0 + i);
        end

        // basic fill of 0x9 -> block 8..11
        row(1, 32'h9, 0, 0, 0, 1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 1, 1, 0, 64'hA0);
        row(0, 0, 0, 0, 0, 1, 1, 0, 64'hA1);
        row(0, 0, 0, 0, 0, 1, 1, 0, 64'hA2);
        row(0, 0, 0, 0, 0, 1, 1, 1, 64'hA3);
        // held request: ignored on edge 6, accepted on edge 7, mid-burst address ignored
        row(1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        row(1, 32'h10, 0, 0, 0, 1, 0, 0, 0);
        row(1, 32'h30, 0, 0, 0, 1, 0, 0, 0);
        row(1, 32'h30, 0, 0, 0, 1, 1, 0, 64'hB0);
        row(1, 32'h30, 0, 0, 0, 1, 1, 0, 64'hB1);
        row(1, 32'h30, 0, 0, 0, 1, 1, 0, 64'hB2);
        row(0, 0, 0, 0, 0, 1, 1, 1, 64'hB3);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // high address bits wrap
        row(1, 32'h403, 0, 0, 0, 1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 1, 1, 0, 64'hD0);
        row(0, 0, 0, 0, 0, 1, 1, 0, 64'hD1);
        row(0, 0, 0, 0, 0, 1, 1, 0, 64'hD2);
        row(0, 0, 0, 0, 0, 1, 1, 1, 64'hD3);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // load during burst: early load seen, same-edge load returns old word
        row(1, 32'h20, 0, 0, 0, 1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 1, 1, 0, 64'hE0);
        row(0, 0, 1, 32'h23, 64'h55, 1, 1, 0, 64'hE1);
        row(0, 0, 1, 32'h22, 64'h55, 1, 1, 0, 64'hE2);
        row(0, 0, 0, 0, 0, 1, 1, 1, 64'h55);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // request and load on the same idle edge
        row(1, 32'h21, 1, 32'h20, 64'h77, 1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 1, 1, 0, 64'h77);
        row(0, 0, 0, 0, 0, 1, 1, 0, 64'hE1);
        row(0, 0, 0, 0, 0, 1, 1, 0, 64'h55);
        row(0, 0, 0, 0, 0, 1, 1, 1, 64'h55);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            b2.fill_req = vecs[i].req; b2.fill_address = vecs[i].addr;
            b2.load_en = vecs[i].ld;   b2.load_address = vecs[i].la; b2.load_data = vecs[i].ldat;
            tick();
            chk($sformatf("vec%0d busy", i), b2.fill_busy, vecs[i].busy);
            chk($sformatf("vec%0d valid", i), b2.fill_valid, vecs[i].vld);
            chk($sformatf("vec%0d last", i), b2.fill_last, vecs[i].last);
            if (vecs[i].vld) chk($sformatf("vec%0d data", i), b2.fill_data, vecs[i].data);
        end
        b2.fill_req = 1'b0; b2.load_en = 1'b0;

        // reset in WAIT
        b2.fill_req = 1'b1; b2.fill_address = 32'h8;
        tick();
        b2.fill_req = 1'b0;
        chk("rw pre busy", b2.fill_busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("rw busy", b2.fill_busy, 0);
        chk("rw valid", b2.fill_valid, 0);
        tick(); tick();
        #2 reset = 1'b1;
        tick(); tick(); tick();
        chk("rw no resume busy", b2.fill_busy, 0);
        chk("rw no resume valid", b2.fill_valid, 0);

        // reset in BURST
        b2.fill_req = 1'b1; b2.fill_address = 32'h8;
        tick();
        b2.fill_req = 1'b0;
        tick(); tick();
        chk("rb pre valid", b2.fill_valid, 1);
        chk("rb pre data", b2.fill_data, 64'hA0);
        #2 reset = 1'b0;
        #1;
        chk("rb busy", b2.fill_busy, 0);
        chk("rb valid", b2.fill_valid, 0);
        chk("rb last", b2.fill_last, 0);
        chk("rb data", b2.fill_data, 0);
        tick();
        #2 reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rb idle%0d valid", i), b2.fill_valid, 0);
        end

        // clean fill after reset
        b2.fill_req = 1'b1; b2.fill_address = 32'h11;
        tick();
        b2.fill_req = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk($sformatf("post e%0d busy", e), b2.fill_busy, (e <= 5) ? 1'b1 : 1'b0);
            chk($sformatf("post e%0d valid", e), b2.fill_valid, (e >= 2 && e <= 5) ? 1'b1 : 1'b0);
            chk($sformatf("post e%0d last", e), b2.fill_last, (e == 5) ? 1'b1 : 1'b0);
            if (e >= 2 && e <= 5) chk($sformatf("post e%0d data", e), b2.fill_data, 64'hB0 + e - 2);
        end

        // LATENCY=1 and LATENCY=5 instances
        for (int d = 0; d < 2; d++) begin
            int lat;
            lat = (d == 0) ? 1 : 5;
            if (d == 0) begin b1.fill_req = 1'b1; b1.fill_address = 32'h42; end
            else        begin b5.fill_req = 1'b1; b5.fill_address = 32'h42; end
            tick();
            b1.fill_req = 1'b0; b5.fill_req = 1'b0;
            n = 0; v = 1'b0;
            while (!v && n < 20) begin
                tick();
                n++;
                v = (d == 0) ? b1.fill_valid : b5.fill_valid;
            end
            chk($sformatf("lat%0d first valid edge", lat), n, lat);
            for (int k = 0; k < 4; k++) begin
                if (k > 0) tick();
                v  = (d == 0) ? b1.fill_valid : b5.fill_valid;
                l  = (d == 0) ? b1.fill_last  : b5.fill_last;
                dd = (d == 0) ? b1.fill_data  : b5.fill_data;
                chk($sformatf("lat%0d w%0d valid", lat, k), v, 1);
                chk($sformatf("lat%0d w%0d last", lat, k), l, (k == 3) ? 1'b1 : 1'b0);
                chk($sformatf("lat%0d w%0d data", lat, k), dd, 64'hF0 + k);
            end
            tick();
            v  = (d == 0) ? b1.fill_valid : b5.fill_valid;
            bz = (d == 0) ? b1.fill_busy  : b5.fill_busy;
            chk($sformatf("lat%0d end valid", lat), v, 0);
            chk($sformatf("lat%0d end busy", lat), bz, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_fill_responder.md
Name: mem_fill_responder

Overview:
- Main-memory responder that serves line-fill requests from the cache controller.
- On a fill request it returns one cache block, BLOCK_WORDS 64-bit words on consecutive cycles, after a fixed access latency.
- Holds its own word-addressed backing store, loaded through a side write port by the testbench or the boot loader.
- Sits between the cache miss path and the system memory model.

Parameters:
- WORD_WIDTH, 64, data word width in bits.
- BLOCK_WORDS, 4, words returned per fill. Fixed to 4; the block offset is 2 bits.
- DEPTH, 1024, backing-store size in words. Must be a power of two, >= BLOCK_WORDS.
- LATENCY, 2, cycles from request acceptance to the first data word. Must be >= 1.

Ports:
- clock  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- fill_req  input  1  fill request, sampled on clock edges.
- fill_address  input  32  word address of the requested word.
- fill_busy  output  1  high from acceptance until the last word has been delivered.
- fill_valid  output  1  fill_data holds a valid block word this cycle.
- fill_last  output  1  high with fill_valid on the final word of the block.
- fill_data  output  WORD_WIDTH  block word.
- load_en  input  1  backing-store write enable.
- load_address  input  32  backing-store write word address.
- load_data  input  WORD_WIDTH  backing-store write data.

Behaviour:
- Reset (reset==0, asynchronous): fill_busy=0, fill_valid=0, fill_last=0, fill_data=0, state=IDLE, counters=0. Backing-store contents are not cleared.
- Addressing:
  - Index = address[log2(DEPTH)-1:0]; higher bits are ignored, so addresses wrap modulo DEPTH.
  - Block base = index with the low 2 bits cleared.
  - Words are returned in ascending order base+0 .. base+3. There is no critical-word-first ordering and no wrap inside the block.
- FSM states: IDLE, WAIT, BURST.
  - IDLE: a request is accepted when fill_req==1 at edge E. The block base is latched, fill_busy=1 after E, the latency counter is loaded, and the FSM goes to WAIT. Requests are accepted only in IDLE; fill_req while busy is ignored and not queued.
  - WAIT: counts LATENCY-1 further edges, then enters BURST. The first word is registered on edge E+LATENCY.
  - BURST: after edges E+LATENCY .. E+LATENCY+3, fill_valid=1 and fill_data=mem[base+k] for k=0..3. fill_last=1 only for k=3.
  - Edge E+LATENCY+4: fill_valid, fill_last and fill_busy drop to 0, and the FSM returns to IDLE.
  - The earliest next acceptance is edge E+LATENCY+5.
- Total fill occupancy is LATENCY+4 cycles of fill_busy.
- fill_data:
  - Registered read.
  - Holds its last value when fill_valid==0. Consumers must qualify it with fill_valid.
- Load port:
  - Writes mem[load index] on every edge with load_en==1, in any state.
  - Same-edge collision with a burst read of the same index: fill_data returns the OLD value; the new value is visible on subsequent reads.
  - A load to a not-yet-sent word of the active burst is returned with the new data.
- Reset mid-operation: the burst is aborted immediately and all outputs go to their reset values. There is no partial completion after reset release.
- Simultaneous fill_req and load_en in IDLE: both take effect. The load is complete before the first word is read, because LATENCY >= 1.

Test Plan:
- Preload mem[8..11]=0xA0..0xA3, LATENCY=2. Pulse fill_req with fill_address=0x9 at edge 0.
  - fill_busy=1 after edges 0..5.
  - fill_valid after edges 2..5, with data 0xA0,0xA1,0xA2,0xA3.
  - fill_last only with 0xA3; busy=0 after edge 6.
- Hold fill_req=1 continuously with address 0x10.
  - Second acceptance at edge 7, not earlier.
  - A different fill_address presented mid-burst is ignored; the burst still returns mem[0x10..0x13].
- fill_address=0x0000_0403 with DEPTH=1024 returns mem[0..3] (wrap via ignored high bits).
- During a burst of base 0x20, load_en writes 0x55 to index 0x22 on the same edge the word at 0x22 is read.
  - fill_data shows the old value.
  - A load to 0x23 one edge earlier shows 0x55 on the last word.
- Assert reset=0 mid-WAIT and again mid-BURST.
  - Outputs go to 0 asynchronously, before the next clock.
  - After release, a new request completes normally with correct data.
- LATENCY=1 and LATENCY=5 builds: first fill_valid appears exactly LATENCY edges after acceptance, and four valid words are always contiguous.
